// File: rtl/mips_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_program_loader
// Purpose  : Assembles 32-bit MIPS instruction words from symbolic fields
//            received on a valid/ready stream and writes them sequentially
//            into instruction memory before the core leaves reset.
//            Supported ops: R-type, addi, andi, ori, sw, lw, beq.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start               - begin a load session (IDLE/DONE only)
//            in_valid/in_ready   - instruction beat handshake
//            in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last
//                                - symbolic instruction fields
//            imem_we/addr/wdata  - instruction-memory write port
//            busy, done, error   - session status (error is sticky)
//            count               - words written this session
// Revision : 1.0 - initial release
// ============================================================================
module mips_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_RESERVED = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic                  last_q;
  logic                  error_q;

  logic                  hs;
  logic                  op_reserved;
  logic                  addr_full;
  logic [31:0]           enc_word;

  assign hs          = in_valid & in_ready;
  assign op_reserved = (in_op == OP_RESERVED);
  // Address about to be written is the last slot of the memory.
  assign addr_full   = &addr_q;

  // Field-to-word encoder; unused fields of each format are dropped.
  always_comb begin
    enc_word = 32'd0;
    case (in_op)
      3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      3'd2:    enc_word = {6'b001100, in_rs, in_rt, in_imm};
      3'd3:    enc_word = {6'b001101, in_rs, in_rt, in_imm};
      3'd4:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd5:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd6:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      default: enc_word = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hs) begin
          if (!op_reserved)  state_d = S_WRITE;
          else if (in_last)  state_d = S_DONE;
          else               state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        if (last_q || addr_full) state_d = S_DONE;
        else                     state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state (no path from in_valid to in_ready).
  always_comb begin
    in_ready = (state_q == S_LOAD);
    imem_we  = (state_q == S_WRITE);
    busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
    done     = (state_q == S_DONE);
  end

  // Datapath: session counters, latched word and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            last_q <= in_last;
            if (op_reserved) begin
              error_q <= 1'b1;
            end else begin
              // Write-port registers only change here, so they hold
              // their values while imem_we is low.
              waddr_q <= addr_q;
              wdata_q <= enc_word;
            end
          end
        end
        S_WRITE: begin
          addr_q  <= addr_q + ADDR_ONE;
          count_q <= count_q + CNT_ONE;
          if (!last_q && addr_full) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign error      = error_q;
  assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_program_loader
// Purpose  : Self-checking bench for mips_program_loader. Two instances share
//            the input stream: ADDR_WIDTH=8 for normal programs and
//            ADDR_WIDTH=2 for memory-overflow sessions; "sel" picks which one
//            is started and observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_program_loader;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst, st, sel, in_valid, in_last;
  logic [2:0] in_op;
  logic [4:0] in_rs, in_rt, in_rd, in_shamt;
  logic [5:0] in_funct;
  logic [15:0] in_imm;

  logic rdy1, we1, busy1, done1, err1;
  logic [7:0] addr1;
  logic [31:0] wd1;
  logic [8:0] cnt1;
  logic rdy2, we2, busy2, done2, err2;
  logic [1:0] addr2;
  logic [31:0] wd2;
  logic [2:0] cnt2;
  logic start1, start2;

  logic m_rdy, m_we, m_busy, m_done, m_err;
  logic [7:0] m_addr;
  logic [31:0] m_wd;
  logic [8:0] m_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t prog[$];
  logic [31:0] exp_d[$];
  int exp_acc;
  logic exp_err;
  logic exp_end_wr;

  logic [7:0]  wa[$];
  logic [31:0] wdq[$];
  int          wc[$];
  int          overlap;
  logic        done_seen;
  int          done_cyc;

  assign start1 = st & ~sel;
  assign start2 = st & sel;

  mips_program_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .busy(busy1), .done(done1), .error(err1), .count(cnt1)
  );

  mips_program_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(rdy2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
    .busy(busy2), .done(done2), .error(err2), .count(cnt2)
  );

  always_comb begin
    m_rdy  = sel ? rdy2  : rdy1;
    m_we   = sel ? we2   : we1;
    m_busy = sel ? busy2 : busy1;
    m_done = sel ? done2 : done1;
    m_err  = sel ? err2  : err1;
    m_addr = sel ? {6'd0, addr2} : addr1;
    m_wd   = sel ? wd2   : wd1;
    m_cnt  = sel ? {6'd0, cnt2} : cnt1;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/ready/done observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_we) begin
      wa.push_back(m_addr);
      wdq.push_back(m_wd);
      wc.push_back(cyc);
    end
    if (m_we && m_rdy) overlap = overlap + 1;
    if (m_done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                               input logic last);
    beat_t b;
    b.op = op; b.rs = rs; b.rt = rt; b.rd = rd; b.sh = 5'd0; b.fn = fn; b.imm = imm; b.last = last;
    return b;
  endfunction

  function automatic beat_t rnd_beat(input logic last);
    beat_t b;
    b.op = ($urandom_range(0, 7) == 7) ? 3'd7 : 3'($urandom_range(0, 6));
    b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom);
    b.sh = 5'($urandom); b.fn = 6'($urandom); b.imm = 16'($urandom);
    b.last = last;
    return b;
  endfunction

  // Reference encoding straight from the MIPS field layouts.
  function automatic logic [31:0] enc(input beat_t b);
    logic [5:0] opc;
    case (b.op)
      3'd1: opc = 6'b001000;
      3'd2: opc = 6'b001100;
      3'd3: opc = 6'b001101;
      3'd4: opc = 6'b101011;
      3'd5: opc = 6'b100011;
      default: opc = 6'b000100;
    endcase
    if (b.op == 3'd0) return {6'b000000, b.rs, b.rt, b.rd, b.sh, b.fn};
    return {opc, b.rs, b.rt, b.imm};
  endfunction

  // Program-level model: which beats get accepted, what lands in memory.
  task automatic model(input int cap);
    exp_d.delete();
    exp_acc = 0; exp_err = 1'b0; exp_end_wr = 1'b0;
    foreach (prog[i]) begin
      exp_acc++;
      if (prog[i].op == 3'd7) begin
        exp_err = 1'b1;
        if (prog[i].last) break;
      end else begin
        exp_d.push_back(enc(prog[i]));
        if (prog[i].last) begin exp_end_wr = 1'b1; break; end
        if (exp_d.size() == cap) begin exp_err = 1'b1; exp_end_wr = 1'b1; break; end
      end
    end
  endtask

  task automatic put(input beat_t b);
    in_op = b.op; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd; in_shamt = b.sh;
    in_funct = b.fn; in_imm = b.imm; in_last = b.last; in_valid = 1'b1;
  endtask

  task automatic pulse_start();
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    chk("start_busy", 64'(m_busy), 64'd1);
    chk("start_ready", 64'(m_rdy), 64'd1);
    wa.delete(); wdq.delete(); wc.delete();
    overlap = 0; done_seen = 1'b0;
  endtask

  // Feeds prog; a beat not accepted within the budget ends the feed.
  task automatic drive(input int gapmax, output int acc);
    int t;
    acc = 0;
    foreach (prog[i]) begin
      repeat ((gapmax > 0) ? $urandom_range(0, gapmax) : 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      put(prog[i]);
      t = 0;
      while (!m_rdy && t < 40) begin @(negedge clk); t++; end
      if (!m_rdy) begin in_valid = 1'b0; return; end
      @(negedge clk);
      acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input int cap, input int gapmax);
    int acc, t;
    model(cap);
    pulse_start();
    drive(gapmax, acc);
    t = 0;
    while (!m_done && t < 60) begin @(negedge clk); t++; end
    @(negedge clk);
    chk({tag, "_done"}, 64'(m_done), 64'd1);
    chk({tag, "_busy"}, 64'(m_busy), 64'd0);
    chk({tag, "_accepted"}, 64'(acc), 64'(exp_acc));
    chk({tag, "_nwrites"}, 64'(wa.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < wa.size(); i++) begin
      chk({tag, "_addr"}, 64'(wa[i]), 64'(i));
      chk({tag, "_data"}, 64'(wdq[i]), 64'(exp_d[i]));
    end
    chk({tag, "_count"}, 64'(m_cnt), 64'(exp_d.size()));
    chk({tag, "_error"}, 64'(m_err), 64'(exp_err));
    chk({tag, "_ready_in_write"}, 64'(overlap), 64'd0);
    if (exp_end_wr && wc.size() > 0) begin
      chk({tag, "_done_latency"}, 64'(done_cyc), 64'(wc[wc.size()-1] + 1));
      chk({tag, "_addr_hold"}, 64'(m_addr), 64'(wa[wa.size()-1]));
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; st = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0; in_imm = '0;
    overlap = 0; done_seen = 1'b0; done_cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst_we", 64'(we1), 64'd0);
    chk("rst_addr", 64'(addr1), 64'd0);
    chk("rst_wdata", 64'(wd1), 64'd0);
    chk("rst_count", 64'(cnt1), 64'd0);
    chk("rst_flags", 64'({busy1, done1, err1, rdy1}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single addi
    prog.delete();
    prog.push_back(mk(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 1'b1));
    run("addi", 256, 0);
    if (wdq.size() > 0) chk("addi_word", 64'(wdq[0]), 64'h20080005);

    // add / lw / sw / beq
    prog.delete();
    prog.push_back(mk(3'd0, 5'd8,  5'd9, 5'd10, 6'h20, 16'h0, 1'b0));
    prog.push_back(mk(3'd5, 5'd29, 5'd8, 5'd0,  6'h0,  16'd4, 1'b0));
    prog.push_back(mk(3'd4, 5'd29, 5'd8, 5'd0,  6'h0,  16'd8, 1'b0));
    prog.push_back(mk(3'd6, 5'd8,  5'd9, 5'd0,  6'h0,  16'hFFFF, 1'b1));
    run("seq", 256, 2);
    if (wdq.size() == 4) begin
      chk("seq_w0", 64'(wdq[0]), 64'h01095020);
      chk("seq_w1", 64'(wdq[1]), 64'h8FA80004);
      chk("seq_w2", 64'(wdq[2]), 64'hAFA80008);
      chk("seq_w3", 64'(wdq[3]), 64'h1109FFFF);
    end

    // Continuous valid: writes exactly two cycles apart
    prog.delete();
    for (int i = 0; i < 6; i++) begin
      prog.push_back(rnd_beat(i == 5));
      if (prog[i].op == 3'd7) prog[i].op = 3'd3;
    end
    run("stream", 256, 0);
    for (int i = 1; i < wc.size(); i++) chk("stream_spacing", 64'(wc[i] - wc[i-1]), 64'd2);

    // Reserved op between two addi beats
    prog.delete();
    prog.push_back(mk(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h1234, 1'b0));
    prog.push_back(mk(3'd7, 5'd3, 5'd4, 5'd5, 6'd0, 16'h0, 1'b0));
    prog.push_back(mk(3'd1, 5'd6, 5'd7, 5'd0, 6'd0, 16'hBEEF, 1'b1));
    run("reserved", 256, 1);

    // Overflow on the 4-word instance
    sel = 1'b1;
    prog.delete();
    for (int i = 0; i < 5; i++) begin
      prog.push_back(rnd_beat(1'b0));
      if (prog[i].op == 3'd7) prog[i].op = 3'd1;
    end
    run("overflow", 4, 1);
    chk("overflow_ready_low", 64'(m_rdy), 64'd0);
    sel = 1'b0;

    // Randomised sessions
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 9);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rnd_beat(i == n - 1));
      run("random", 256, 3);
    end

    // Reset in the middle of a WRITE
    prog.delete();
    prog.push_back(mk(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h00FF, 1'b0));
    pulse_start();
    put(prog[0]);
    t = 0;
    while (!m_we && t < 20) begin @(negedge clk); t++; end
    in_valid = 1'b0;
    chk("midrst_reached_write", 64'(m_we), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", 64'(m_we), 64'd0);
    chk("midrst_busy", 64'(m_busy), 64'd0);
    chk("midrst_count", 64'(m_cnt), 64'd0);
    chk("midrst_outs", 64'({m_done, m_err, m_rdy, m_addr, m_wd}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    prog.delete();
    prog.push_back(mk(3'd3, 5'd9, 5'd10, 5'd0, 6'd0, 16'h0F0F, 1'b0));
    prog.push_back(mk(3'd0, 5'd1, 5'd2,  5'd3, 6'h22, 16'h0, 1'b1));
    run("restart", 256, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_program_loader.md
# mips_program_loader

Instruction encoder and loader for the single-cycle MIPS core: the encoding-side counterpart of the opcode decoder. It accepts symbolic instruction fields over a valid/ready stream and assembles 32-bit MIPS words for the supported opcode set: R-type, addi, andi, ori, sw, lw, beq. It writes the words sequentially into instruction memory before the core is released from reset. It sits between the testbench/boot source and the instruction memory write port.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session; honoured only in IDLE or DONE
- in_valid  in  1  instruction beat valid
- in_ready  out  1  loader can accept a beat; high only in LOAD
- in_op  in  3  0=R-type, 1=addi, 2=andi, 3=ori, 4=sw, 5=lw, 6=beq, 7=reserved
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_funct  in  6  R-type function field
- in_imm  in  16  immediate / branch offset (raw, no sign handling)
- in_last  in  1  final instruction of the program
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD or WRITE
- done  out  1  high in DONE
- error  out  1  sticky: reserved op seen or memory overflow; cleared by rst or start
- count  out  ADDR_WIDTH+1  words written this session

## Operation
- States: IDLE, LOAD, WRITE, DONE. Reset → IDLE. On reset, all outputs and registers are 0: imem_we, imem_addr, imem_wdata, count, error, done, busy.
- IDLE/DONE: start=1 → LOAD. Address counter, count, and error are cleared.
- LOAD: in_ready=1. A handshake (in_valid & in_ready) latches the encoded word and in_last.
  - Valid op → WRITE.
  - Reserved op (7): error:=1, nothing is written. If in_last=1 → DONE, otherwise stay in LOAD.
- WRITE: imem_we=1 with imem_addr=current address and imem_wdata=latched word. At the end of the cycle, address+1 and count+1.
  - Latched last=1 → DONE.
  - Else if the address just written is all-ones (memory full) → DONE with error:=1.
  - Else → LOAD.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {opcode, rs, rt, imm}.
  - Opcodes: addi 6'b001000, andi 6'b001100, ori 6'b001101, sw 6'b101011, lw 6'b100011, beq 6'b000100.
  - Fields not used by the format are ignored.
- start in LOAD or WRITE is ignored.
- DONE holds until start or rst. in_ready=0 in IDLE, WRITE, and DONE.
- imem_addr and imem_wdata hold their last values when imem_we=0.

## Timing
- in_ready is decoded from state, with no combinational path from in_valid.
- Handshake in cycle N → imem_we high in cycle N+1 → in_ready high again in cycle N+2. Peak throughput is 1 word per 2 cycles.
- start sampled in cycle N → busy and in_ready high in N+1.
- done rises the cycle after the final WRITE cycle.
- count is updated in the same edge that ends the WRITE cycle.
- rst mid-session: next cycle is IDLE with all outputs 0. A partially written memory is left as is.

## Test plan
- Single addi with rs=0, rt=8, imm=5, in_last=1 → one write: addr 0, data 0x20080005; then done=1, count=1, error=0.
- Sequence add (rs=8, rt=9, rd=10, funct=0x20), lw (rs=29, rt=8, imm=4), sw (rs=29, rt=8, imm=8), beq (rs=8, rt=9, imm=0xFFFF, last):
  - Expected writes, addrs 0..3: 0x01095020, 0x8FA80004, 0xAFA80008, 0x1109FFFF.
  - Then count=4.
- in_valid held high continuously → writes are spaced exactly 2 cycles apart, and in_ready never asserts in a WRITE cycle.
- Reserved op=7 between two addi beats → error=1, only 2 writes (addrs 0, 1), with no address gap.
- ADDR_WIDTH=2, 5 beats with no in_last → 4 writes at addrs 0..3, then DONE with error=1. The 5th beat is never accepted (in_ready stays 0).
- rst asserted during WRITE → next cycle imem_we=0, busy=0, count=0. A following start restarts at addr 0.
